// File: rtl/pipe_pkg.sv
// Shared definitions for the three-stage pipeline controller: control-word
// field positions, write-back select encodings, forwarding codes and FSM states.
package pipe_pkg;

  localparam int unsigned CtrlW = 16;
  localparam int unsigned RegW  = 5;

  // Control-word field bit positions
  localparam int unsigned RegWEnBit = 0;
  localparam int unsigned ImmSelLsb = 1;
  localparam int unsigned ImmSelMsb = 3;
  localparam int unsigned BrLUnBit  = 4;
  localparam int unsigned ASelBit   = 5;
  localparam int unsigned BSelBit   = 6;
  localparam int unsigned AluSelLsb = 7;
  localparam int unsigned AluSelMsb = 10;
  localparam int unsigned MemRWBit  = 11;
  localparam int unsigned WbSelLsb  = 12;
  localparam int unsigned WbSelMsb  = 13;
  localparam int unsigned PcSelLsb  = 14;
  localparam int unsigned PcSelMsb  = 15;

  // Write-back select encodings
  localparam logic [1:0] WBSEL_MEM = 2'b00;
  localparam logic [1:0] WBSEL_ALU = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;

  // EX operand source codes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StMemWait
  } pipe_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX source register.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic            wb_valid_i,
  input  logic            wb_regwen_i,
  input  logic [RegW-1:0] wb_rd_i,
  input  logic [RegW-1:0] ex_rs_i,
  output logic [1:0]      fwd_o
);

  // Take the WB result only when it really writes a non-x0 register we read
  always_comb begin
    fwd_o = FWD_RF;
    if (wb_valid_i && wb_regwen_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ID -> EX -> WB control pipeline with branch flush, memory freeze and forwarding.
module pipeline_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [CtrlW-1:0] id_ctrl,
  input  logic [RegW-1:0]  id_rd,
  input  logic [RegW-1:0]  id_rs1,
  input  logic [RegW-1:0]  id_rs2,
  input  logic             ex_redirect,
  input  logic             mem_ready,
  output logic [CtrlW-1:0] ex_ctrl,
  output logic [CtrlW-1:0] wb_ctrl,
  output logic             ex_valid,
  output logic             wb_valid,
  output logic [RegW-1:0]  ex_rd,
  output logic [RegW-1:0]  wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_if,
  output logic [31:0]      bubble_cnt
);

  pipe_state_e      st_q, st_d;
  logic             ex_valid_q, ex_valid_d, wb_valid_q, wb_valid_d;
  logic [CtrlW-1:0] ex_ctrl_q, ex_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [RegW-1:0]  ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic [RegW-1:0]  ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [31:0]      bubble_cnt_q, bubble_cnt_d;
  // Redirect / flush that arrived while frozen, replayed on release
  logic             pend_redir_q, pend_redir_d, pend_flush_q, pend_flush_d;
  logic             mem_acc, freeze, redir_now, flush_now;

  // Next-state: freeze holds everything, otherwise redirect, flush or normal advance
  always_comb begin
    st_d         = st_q;
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rd_d      = ex_rd_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    wb_valid_d   = wb_valid_q;
    wb_ctrl_d    = wb_ctrl_q;
    wb_rd_d      = wb_rd_q;
    bubble_cnt_d = bubble_cnt_q;
    pend_redir_d = pend_redir_q;
    pend_flush_d = pend_flush_q;

    mem_acc   = wb_valid_q && ((wb_ctrl_q[WbSelMsb:WbSelLsb] == WBSEL_MEM) ||
                               wb_ctrl_q[MemRWBit]);
    freeze    = mem_acc && !mem_ready;
    // A redirect only means something when EX holds a real instruction
    redir_now = (ex_redirect && ex_valid_q) || pend_redir_q;
    flush_now = (st_q == StFlush) || pend_flush_q;

    if (freeze) begin
      st_d         = StMemWait;
      pend_redir_d = redir_now;
      pend_flush_d = flush_now && !redir_now;
    end else begin
      pend_redir_d = 1'b0;
      pend_flush_d = 1'b0;
      wb_valid_d   = ex_valid_q;
      wb_ctrl_d    = ex_ctrl_q;
      wb_rd_d      = ex_rd_q;
      if (redir_now || flush_now) begin
        // Kill whatever is in ID: the wrong-path instruction, then the stale fetch
        st_d         = redir_now ? StFlush : StRun;
        ex_valid_d   = 1'b0;
        ex_ctrl_d    = '0;
        ex_rd_d      = '0;
        ex_rs1_d     = '0;
        ex_rs2_d     = '0;
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
        st_d       = StRun;
        ex_valid_d = id_valid;
        ex_ctrl_d  = id_valid ? id_ctrl : '0;
        ex_rd_d    = id_valid ? id_rd   : '0;
        ex_rs1_d   = id_valid ? id_rs1  : '0;
        ex_rs2_d   = id_valid ? id_rs2  : '0;
      end
    end
  end

  // State and stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= StRun;
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_ctrl_q    <= '0;
      wb_rd_q      <= '0;
      bubble_cnt_q <= '0;
      pend_redir_q <= 1'b0;
      pend_flush_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      wb_valid_q   <= wb_valid_d;
      wb_ctrl_q    <= wb_ctrl_d;
      wb_rd_q      <= wb_rd_d;
      bubble_cnt_q <= bubble_cnt_d;
      pend_redir_q <= pend_redir_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  fwd_sel u_fwd_a (
    .wb_valid_i  (wb_valid_q),
    .wb_regwen_i (wb_ctrl_q[RegWEnBit]),
    .wb_rd_i     (wb_rd_q),
    .ex_rs_i     (ex_rs1_q),
    .fwd_o       (fwd_a)
  );

  fwd_sel u_fwd_b (
    .wb_valid_i  (wb_valid_q),
    .wb_regwen_i (wb_ctrl_q[RegWEnBit]),
    .wb_rd_i     (wb_rd_q),
    .ex_rs_i     (ex_rs2_q),
    .fwd_o       (fwd_b)
  );

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rd      = ex_rd_q;
  assign wb_valid   = wb_valid_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign wb_rd      = wb_rd_q;
  assign stall_if   = freeze;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [15:0] id_ctrl = '0;
  logic [4:0]  id_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic        ex_redirect = 1'b0;
  logic        mem_ready = 1'b1;
  logic [15:0] ex_ctrl, wb_ctrl;
  logic        ex_valid, wb_valid;
  logic [4:0]  ex_rd, wb_rd;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall_if;
  logic [31:0] bubble_cnt;

  localparam logic [15:0] ADD = 16'h1001; // RegWEn, WBSel=ALU
  localparam logic [15:0] LW  = 16'h0041; // RegWEn, BSel, WBSel=mem
  localparam logic [15:0] BEQ = 16'h5000; // PCSel=01, WBSel=ALU, no write
  localparam logic [15:0] Z   = 16'h0000;

  typedef struct packed {
    logic [7:0]  idx;
    logic        ev;
    logic [15:0] ec;
    logic [4:0]  er;
    logic        wv;
    logic [15:0] wc;
    logic [4:0]  wr;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [31:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ctrl     (id_ctrl),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_redirect (ex_redirect),
    .mem_ready   (mem_ready),
    .ex_ctrl     (ex_ctrl),
    .wb_ctrl     (wb_ctrl),
    .ex_valid    (ex_valid),
    .wb_valid    (wb_valid),
    .ex_rd       (ex_rd),
    .wb_rd       (wb_rd),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_if    (stall_if),
    .bubble_cnt  (bubble_cnt)
  );

  function automatic exp_t mk(logic ev, logic [15:0] ec, logic [4:0] er, logic wv,
                              logic [15:0] wc, logic [4:0] wr, logic [1:0] fa,
                              logic [1:0] fb, logic st, logic [31:0] bc);
    exp_t e;
    e.idx = 8'd0;
    e.ev = ev; e.ec = ec; e.er = er;
    e.wv = wv; e.wc = wc; e.wr = wr;
    e.fa = fa; e.fb = fb; e.st = st; e.bc = bc;
    return e;
  endfunction

  // Drive one cycle of inputs after the edge and queue the outputs expected this cycle
  task automatic vec(input logic rn, input logic idv, input logic [15:0] c,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic redir, input logic mrdy, input exp_t e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n       = rn;
    id_valid    = idv;
    id_ctrl     = c;
    id_rd       = rd;
    id_rs1      = rs1;
    id_rs2      = rs2;
    ex_redirect = redir;
    mem_ready   = mrdy;
    x     = e;
    x.idx = vec_n[7:0];
    exp_q.push_back(x);
    vec_n++;
  endtask

  task automatic chk(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, nm, act, want);
    end
  endtask

  // Monitor: compare whatever the DUT shows at the falling edge against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(int'(e.idx), "ex_valid",   {31'd0, ex_valid}, {31'd0, e.ev});
      chk(int'(e.idx), "ex_ctrl",    {16'd0, ex_ctrl},  {16'd0, e.ec});
      chk(int'(e.idx), "ex_rd",      {27'd0, ex_rd},    {27'd0, e.er});
      chk(int'(e.idx), "wb_valid",   {31'd0, wb_valid}, {31'd0, e.wv});
      chk(int'(e.idx), "wb_ctrl",    {16'd0, wb_ctrl},  {16'd0, e.wc});
      chk(int'(e.idx), "wb_rd",      {27'd0, wb_rd},    {27'd0, e.wr});
      chk(int'(e.idx), "fwd_a",      {30'd0, fwd_a},    {30'd0, e.fa});
      chk(int'(e.idx), "fwd_b",      {30'd0, fwd_b},    {30'd0, e.fb});
      chk(int'(e.idx), "stall_if",   {31'd0, stall_if}, {31'd0, e.st});
      chk(int'(e.idx), "bubble_cnt", bubble_cnt,        e.bc);
    end
  end

  initial begin
    // Reset state
    vec(0, 0, Z,   0, 0, 0, 0, 1, mk(0, Z,   0, 0, Z,   0, 0, 0, 0, 0));
    // Back-to-back ALU forwarding, and the x0 destination case
    vec(1, 1, ADD, 5, 1, 2, 0, 1, mk(0, Z,   0, 0, Z,   0, 0, 0, 0, 0));
    vec(1, 1, ADD, 6, 5, 5, 0, 1, mk(1, ADD, 5, 0, Z,   0, 0, 0, 0, 0));
    vec(1, 1, ADD, 0, 6, 3, 0, 1, mk(1, ADD, 6, 1, ADD, 5, 1, 1, 0, 0));
    vec(1, 1, ADD, 7, 0, 0, 0, 1, mk(1, ADD, 0, 1, ADD, 6, 1, 0, 0, 0));
    vec(1, 0, Z,   0, 0, 0, 0, 1, mk(1, ADD, 7, 1, ADD, 0, 0, 0, 0, 0));
    // Redirect at v7: two bubbles, target enters EX at v10
    vec(1, 1, BEQ, 0, 7, 1, 0, 1, mk(0, Z,   0, 1, ADD, 7, 0, 0, 0, 0));
    vec(1, 1, ADD, 8, 1, 2, 1, 1, mk(1, BEQ, 0, 0, Z,   0, 0, 0, 0, 0));
    vec(1, 1, ADD, 9, 1, 2, 0, 1, mk(0, Z,   0, 1, BEQ, 0, 0, 0, 0, 1));
    vec(1, 1, ADD, 10, 0, 0, 0, 1, mk(0, Z,  0, 0, Z,   0, 0, 0, 0, 2));
    vec(1, 1, LW,  11, 2, 0, 0, 1, mk(1, ADD, 10, 0, Z,  0, 0, 0, 0, 2));
    // Load in WB with mem_ready low for three cycles
    vec(1, 1, ADD, 12, 11, 10, 0, 1, mk(1, LW, 11, 1, ADD, 10, 0, 0, 0, 2));
    vec(1, 1, ADD, 13, 1, 1, 0, 0, mk(1, ADD, 12, 1, LW, 11, 1, 0, 1, 2));
    vec(1, 1, ADD, 13, 1, 1, 0, 0, mk(1, ADD, 12, 1, LW, 11, 1, 0, 1, 2));
    vec(1, 1, ADD, 13, 1, 1, 0, 0, mk(1, ADD, 12, 1, LW, 11, 1, 0, 1, 2));
    vec(1, 1, ADD, 13, 1, 1, 0, 1, mk(1, ADD, 12, 1, LW, 11, 1, 0, 0, 2));
    vec(1, 1, LW,  14, 0, 0, 0, 1, mk(1, ADD, 13, 1, ADD, 12, 0, 0, 0, 2));
    // Redirect coincident with a freeze: deferred until mem_ready
    vec(1, 1, BEQ, 0, 14, 0, 0, 1, mk(1, LW, 14, 1, ADD, 13, 0, 0, 0, 2));
    vec(1, 1, ADD, 15, 1, 2, 1, 0, mk(1, BEQ, 0, 1, LW, 14, 1, 0, 1, 2));
    vec(1, 1, ADD, 15, 1, 2, 1, 0, mk(1, BEQ, 0, 1, LW, 14, 1, 0, 1, 2));
    vec(1, 1, ADD, 15, 1, 2, 1, 1, mk(1, BEQ, 0, 1, LW, 14, 1, 0, 0, 2));
    vec(1, 1, ADD, 16, 1, 2, 0, 1, mk(0, Z,   0, 1, BEQ, 0, 0, 0, 0, 3));
    vec(1, 1, ADD, 17, 0, 0, 0, 1, mk(0, Z,   0, 0, Z,   0, 0, 0, 0, 4));
    vec(1, 1, LW,  18, 0, 0, 0, 1, mk(1, ADD, 17, 0, Z,  0, 0, 0, 0, 4));
    // Reset pulsed while frozen on a load
    vec(1, 1, ADD, 19, 0, 0, 0, 1, mk(1, LW, 18, 1, ADD, 17, 0, 0, 0, 4));
    vec(1, 1, ADD, 19, 0, 0, 0, 0, mk(1, ADD, 19, 1, LW, 18, 0, 0, 1, 4));
    vec(0, 1, ADD, 20, 0, 0, 0, 0, mk(0, Z,   0, 0, Z,   0, 0, 0, 0, 0));
    vec(1, 1, ADD, 20, 0, 0, 0, 0, mk(0, Z,   0, 0, Z,   0, 0, 0, 0, 0));
    vec(1, 0, Z,   0, 0, 0, 0, 1, mk(1, ADD, 20, 0, Z,   0, 0, 0, 0, 0));
    vec(1, 0, Z,   0, 0, 0, 0, 1, mk(0, Z,   0, 1, ADD, 20, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL use one clock `clk` and reset `rst_n`; `rst_n` is asynchronous and active-low.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_ctrl  in  16  decoded control word; fields: [0] RegWEn, [3:1] ImmSel, [4] BrLUn, [5] ASel, [6] BSel, [10:7] ALUSel, [11] MemRW, [13:12] WBSel, [15:14] PCSel
- id_rd, id_rs1, id_rs2  in  5 each  decode register indices
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- mem_ready  in  1  data memory has completed the WB-stage access
- ex_ctrl, wb_ctrl  out  16  control word registered into EX / WB
- ex_valid, wb_valid  out  1  stage holds a real instruction
- ex_rd, wb_rd  out  5  destination index per stage
- fwd_a, fwd_b  out  2  EX operand source: 00 regfile, 01 WB result
- stall_if  out  1  hold PC and IF/ID register
- bubble_cnt  out  32  count of bubbles inserted

Function
REQ-003 Pipeline: ID -> EX -> WB, one register stage each; control words advance one stage per cycle when not frozen.
REQ-004 A memory access is a valid WB instruction with WBSel==00 (load) or MemRW==1 (store).
REQ-005 FSM states: RUN, FLUSH, MEM_WAIT; reset state RUN.
REQ-006 RUN, ex_redirect=1: ex_valid<=0 next cycle (ID killed), go FLUSH.
REQ-007 FLUSH lasts exactly one cycle: id_valid ignored (stale fetch), ex_valid<=0, then RUN; net two bubbles per redirect.
REQ-008 RUN/FLUSH, memory access in WB and mem_ready=0: go MEM_WAIT; EX and WB registers hold, stall_if=1 combinationally in the same cycle.
REQ-009 MEM_WAIT: all stage registers hold, stall_if=1; on mem_ready=1 advance normally that edge and return to RUN.
REQ-010 Priority: memory freeze > redirect; an ex_redirect seen during freeze is deferred and acted on the cycle the freeze releases (held EX instruction retains its redirect).
REQ-011 Valid=0 stages SHALL carry ctrl=16'h0000 and rd=0 (RegWEn=0, MemRW=0).
REQ-012 fwd_a=01 iff wb_valid, wb_ctrl[0]=1, wb_rd!=0, wb_rd==EX rs1; fwd_b likewise for rs2; else 00; combinational.
REQ-013 EX rs1/rs2 SHALL be registered internally alongside ex_ctrl.
REQ-014 stall_if=1 only in freeze; FLUSH does not stall fetch.
REQ-015 bubble_cnt increments by 1 each non-frozen cycle ex_valid is loaded with 0 while id_valid=1 or redirect/FLUSH kills; wraps at 2^32.

Reset
REQ-016 On rst_n=0: state RUN, ex_valid=wb_valid=0, ex_ctrl=wb_ctrl=0, ex_rd=wb_rd=0, fwd_a=fwd_b=00, stall_if=0, bubble_cnt=0.
REQ-017 Reset asserted mid-freeze or mid-FLUSH SHALL discard the pending state; first post-reset instruction enters EX normally.

Structure
REQ-018 A shared package pipe_pkg SHALL hold control-word field bit positions, WBSel encodings (00 mem, 01 ALU, 10 PC+4), FWD_* codes, and the FSM state enum.
REQ-019 Forwarding comparison SHALL be a sub-module fwd_sel (combinational, instanced once per operand).

Verification
REQ-020 Back-to-back ALU: ADD x5 (RegWEn=1, WBSel=01) then ADD using rs1=x5 -> fwd_a=01 in second op's EX cycle; rd=x0 variant -> fwd_a=00.
REQ-021 Redirect: ex_redirect=1 at cycle N -> ex_valid=0 at N+1 and N+2, ex_valid=1 at N+3, bubble_cnt=+2.
REQ-022 Load with mem_ready low 3 cycles -> stall_if=1 for 3 cycles, wb_ctrl/ex_ctrl constant, advance on 4th.
REQ-023 ex_redirect=1 coincident with freeze -> no flush until mem_ready=1, then two bubbles.
REQ-024 rst_n pulsed low during MEM_WAIT -> all outputs zero asynchronously, state RUN after release.
